enc_multi_reader: RTL and testbench
===================================

# enc_multi_reader

Multi-channel successor to the single-input encoder edge reader. It synchronises and deglitches N_CH encoder inputs and timestamps every accepted edge with the free-running counter_in. It holds one pending event per channel and serialises the events round-robin onto a single AXI4-Stream master with full backpressure. It sits between the encoder pins and the DMA/FIFO stream path, in the same clock domain as the timestamp counter.

## Interface
- N_CH, 4: number of encoder channels, 1..16.
- SYNC_STAGES, 2: synchroniser flops per input, ≥2.
- FILT_LEN, 3: consecutive identical synchronised samples required to accept a new level, 1..255. A value of 1 means no filtering.
- TS_WIDTH, 64: timestamp width.

Ports:
- clk  in  1  single clock, rising edge.
- areset  in  1  reset; synchronous, active-high.
- enc_in  in  N_CH  raw asynchronous encoder inputs; bit i is channel i.
- counter_in  in  TS_WIDTH  free-running timestamp, sampled as-is.
- m_axis_tdata  out  TS_WIDTH  event timestamp.
- m_axis_tuser  out  CH_W+1  {channel index [CH_W:1], new level [0]}, where CH_W = max(1, clog2(N_CH)).
- m_axis_tvalid  out  1  event valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on a beat when no other channel is pending.
- overflow  out  N_CH  sticky per-channel event-loss flag.
- drop_cnt  out  32  total lost events; present only with ENC_MULTI_DROP_CNT_EN.

## Operation
- Per channel, in this order:
  - SYNC_STAGES-flop synchroniser.
  - Filter counter: the filtered level changes only after FILT_LEN consecutive synchronised samples differ from the current filtered level. Any matching sample clears the counter.
  - The filtered level's reset value is 0. An input held high through reset therefore yields one rising event after release.
- Edge event: in the cycle the filtered level toggles, the channel asserts a one-cycle pulse carrying {counter_in of that cycle, new level}.
- Pending slot per channel: {valid, ts, level}.
  - An event loads the slot on the next edge.
  - If the slot is still valid and not being drained that cycle, the new event is dropped. The slot keeps the older event, overflow[i] is set, and drop_cnt is incremented.
  - If the slot is drained in the same cycle the event arrives, the slot reloads with the new event and no drop is recorded.
- Arbiter:
  - Round-robin over valid slots, active only while the output register is empty or being accepted (tvalid=0 or tready=1).
  - The grant goes to the lowest valid index ≥ rr_ptr, wrapping around.
  - After a grant, rr_ptr = (grant+1) mod N_CH. rr_ptr resets to 0.
- Output register:
  - The granted slot moves into the output register and its valid bit clears in the same cycle.
  - tlast = 1 when no other slot is valid at load time.
- overflow[i] clears only on reset. drop_cnt saturates at 0xFFFFFFFF.

## Timing
- Reset values: m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, overflow=0, drop_cnt=0, all slots invalid, filter counters 0.
- Latency from enc_in change to the edge pulse is SYNC_STAGES+FILT_LEN cycles.
- Latency from edge pulse to tvalid is 2 cycles when idle: slot load, then output register load.
- AXI-S rules:
  - Once tvalid=1, tdata/tuser/tlast are stable until tvalid&tready.
  - tvalid never depends combinationally on tready.
  - With tready held at 1, one beat is produced per cycle.
- Reset asserted mid-transfer drops the beat in flight and every pending slot. tvalid is 0 in the cycle after reset is sampled.
- Simultaneous edges on several channels each load their own slot; none are lost. They are emitted in round-robin order.
- Maximum sustainable event rate per channel is one per FILT_LEN cycles. The filter guarantees this spacing.

## Configuration
- ENC_MULTI_DROP_CNT_EN defined: the drop_cnt port and its 32-bit saturating counter exist. Increments are +1 per dropped event, summed over channels in the same cycle.
- ENC_MULTI_DROP_CNT_EN undefined: the drop_cnt port and counter are absent. overflow is unchanged.

## Structure
- Package enc_pkg:
  - CH_W computation function.
  - tuser field offsets: LEVEL_BIT=0, CH_LSB=1.
  - Pending-slot struct typedef.
  - Drop counter width constant, 32.
- Sub-module enc_edge_det, instantiated N_CH times: synchroniser + filter + edge pulse. Outputs are level, pulse and captured timestamp.

## Test plan
- N_CH=4, FILT_LEN=3: ch2 goes 0→1 at a counter value of 1000. Expect one beat with tuser={2,1} and tdata = counter value at pulse (1000+SYNC_STAGES+FILT_LEN), tlast=1.
- Glitch: a 2-cycle high pulse on ch0 with FILT_LEN=3 produces no beat. A 3-cycle pulse produces a rise beat then a fall beat.
- All 4 channels rise in the same cycle with tready=1. Expect 4 consecutive beats in ch order 0,1,2,3, identical tdata, and tlast only on ch3.
- Hold tready=0 and toggle ch1 three times. Expect overflow[1]=1 and drop_cnt=1; after release, the beats are the first rise and the fall that followed it.
- Backpressure: toggle tready randomly. Check tdata/tuser stability while tvalid&!tready and check no duplicated beats.
- Assert areset while tvalid=1 with 2 slots pending. Expect tvalid=0 the next cycle, overflow=0, and no stale beats after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants, types and helpers for the multi-channel encoder reader.
package enc_pkg;

  localparam int LEVEL_BIT  = 0;
  localparam int CH_LSB     = 1;
  localparam int DROP_CNT_W = 32;
  localparam int TS_MAX_W   = 64;

  // One buffered event per channel; ts is sized for the widest supported timestamp.
  typedef struct packed {
    logic                valid;
    logic                level;
    logic [TS_MAX_W-1:0] ts;
  } slot_t;

  function automatic int calc_ch_w(input int n_ch);
    int w;
    w = $clog2(n_ch);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/enc_edge_det.sv
// Per-channel synchroniser, run-length deglitch filter and edge pulse.
// The pulse is high in the cycle the filtered level has just toggled; ts is that cycle's timestamp.
module enc_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TS_WIDTH    = 64
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                enc_in,
  input  logic [TS_WIDTH-1:0] counter_in,
  output logic                level,
  output logic                pulse,
  output logic [TS_WIDTH-1:0] ts
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [7:0]             filt_cnt_r;
  logic                   level_r;
  logic                   pulse_r;
  logic                   differ_s;
  logic                   accept_s;

  // Filter decision: accept the new level on the FILT_LEN-th consecutive differing sample
  always_comb begin
    differ_s = (sync_r[SYNC_STAGES-1] != level_r);
    accept_s = differ_s && (filt_cnt_r == 8'(FILT_LEN - 1));
  end

  // Synchroniser shift chain
  always_ff @(posedge clk) begin
    if (areset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], enc_in};
    end
  end

  // Filter counter, filtered level and registered edge pulse
  always_ff @(posedge clk) begin
    if (areset) begin
      filt_cnt_r <= 8'd0;
      level_r    <= 1'b0;
      pulse_r    <= 1'b0;
    end else begin
      pulse_r <= accept_s;
      if (accept_s) begin
        level_r    <= ~level_r;
        filt_cnt_r <= 8'd0;
      end else if (differ_s) begin
        filt_cnt_r <= filt_cnt_r + 8'd1;
      end else begin
        filt_cnt_r <= 8'd0;
      end
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;
  assign ts    = counter_in;

endmodule

// File: rtl/enc_multi_reader.sv
// N_CH encoder edge reader: per-channel pending slot, round-robin serialisation onto AXI4-Stream.
// Optional feature macro: ENC_MULTI_DROP_CNT_EN adds the saturating drop_cnt output.
module enc_multi_reader
  import enc_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TS_WIDTH    = 64,
  localparam int CH_W       = calc_ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [N_CH-1:0]       enc_in,
  input  logic [TS_WIDTH-1:0]   counter_in,
  output logic [TS_WIDTH-1:0]   m_axis_tdata,
  output logic [CH_W:0]         m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [N_CH-1:0]       overflow
`ifdef ENC_MULTI_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [N_CH-1:0]     pulse_s;
  logic [N_CH-1:0]     lvl_s;
  logic [TS_WIDTH-1:0] ts_s [N_CH];

  slot_t               slot_r [N_CH];
  logic [N_CH-1:0]     valid_vec_s;
  logic [N_CH-1:0]     drain_s;
  logic [N_CH-1:0]     drop_s;
  logic [N_CH-1:0]     overflow_r;

  logic                arb_en_s;
  logic                grant_found_s;
  logic [CH_W-1:0]     grant_idx_s;
  logic [CH_W-1:0]     rr_ptr_r;
  logic [CH_W-1:0]     rr_next_s;
  slot_t               gslot_s;
  logic [N_CH-1:0]     others_s;

  logic [TS_WIDTH-1:0] tdata_r;
  logic [CH_W:0]       tuser_r;
  logic                tvalid_r;
  logic                tlast_r;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    enc_edge_det #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .TS_WIDTH   (TS_WIDTH)
    ) u_det (
      .clk       (clk),
      .areset    (areset),
      .enc_in    (enc_in[g]),
      .counter_in(counter_in),
      .level     (lvl_s[g]),
      .pulse     (pulse_s[g]),
      .ts        (ts_s[g])
    );
  end

  // Round-robin grant: first valid slot at or after rr_ptr, wrapping
  always_comb begin
    int              sum;
    logic [CH_W-1:0] idx;
    sum           = 0;
    idx           = '0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < N_CH; i++) begin
      valid_vec_s[i] = slot_r[i].valid;
    end
    for (int k = 0; k < N_CH; k++) begin
      sum = int'(rr_ptr_r) + k;
      if (sum >= N_CH) begin
        sum = sum - N_CH;
      end else begin
        sum = sum;
      end
      idx = CH_W'(sum);
      if (!grant_found_s && valid_vec_s[idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = idx;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Arbiter enable, per-slot drain/drop decisions, and the data for the output register
  always_comb begin
    arb_en_s = !tvalid_r || m_axis_tready;
    gslot_s  = slot_r[grant_idx_s];
    others_s = valid_vec_s & ~(N_CH'(1) << grant_idx_s);
    if (int'(grant_idx_s) == N_CH - 1) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + CH_W'(1);
    end
    for (int i = 0; i < N_CH; i++) begin
      drain_s[i] = arb_en_s && grant_found_s && (grant_idx_s == CH_W'(i));
      drop_s[i]  = pulse_s[i] && slot_r[i].valid && !drain_s[i];
    end
  end

  // Pending slots: load on event, clear on grant, keep the older event when full
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < N_CH; i++) begin
        slot_r[i] <= '0;
      end
      overflow_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (drop_s[i]) begin
          overflow_r[i] <= 1'b1;
        end else if (pulse_s[i]) begin
          slot_r[i].valid <= 1'b1;
          slot_r[i].level <= lvl_s[i];
          slot_r[i].ts    <= TS_MAX_W'(ts_s[i]);
        end else if (drain_s[i]) begin
          slot_r[i].valid <= 1'b0;
        end
      end
    end
  end

  // AXI4-Stream output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (areset) begin
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
      tuser_r  <= '0;
      tlast_r  <= 1'b0;
      rr_ptr_r <= '0;
    end else if (arb_en_s) begin
      if (grant_found_s) begin
        tvalid_r                <= 1'b1;
        tdata_r                 <= gslot_s.ts[TS_WIDTH-1:0];
        tuser_r[LEVEL_BIT]      <= gslot_s.level;
        tuser_r[CH_LSB +: CH_W] <= grant_idx_s;
        tlast_r                 <= (others_s == '0);
        rr_ptr_r                <= rr_next_s;
      end else begin
        tvalid_r <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tuser  = tuser_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign overflow      = overflow_r;

`ifdef ENC_MULTI_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  logic [DROP_CNT_W-1:0] drop_inc_s;
  logic [DROP_CNT_W:0]   drop_sum_s;

  // Number of events lost this cycle across all channels
  always_comb begin
    drop_inc_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_inc_s = drop_inc_s + DROP_CNT_W'(drop_s[i]);
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {1'b0, drop_inc_s};
  end

  // Saturating total of lost events
  always_ff @(posedge clk) begin
    if (areset) begin
      drop_cnt_r <= '0;
    end else if (drop_sum_s[DROP_CNT_W]) begin
      drop_cnt_r <= {DROP_CNT_W{1'b1}};
    end else begin
      drop_cnt_r <= drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_enc_multi_reader.sv
// Directed self-checking bench for enc_multi_reader (N_CH=4, SYNC_STAGES=2, FILT_LEN=3).
module tb_enc_multi_reader;

  localparam int LAT = 5;  // SYNC_STAGES + FILT_LEN

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  enc;
  logic [63:0] counter;
  logic [63:0] tdata;
  logic [2:0]  tuser;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [3:0]  overflow;
`ifdef ENC_MULTI_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  user;
    logic        last;
    logic [63:0] cyc;
  } beat_t;
  beat_t q[$];

  typedef struct {
    logic [3:0] enc;
    logic [2:0] user;
    logic       last;
  } vec_t;
  vec_t vecs[6];

  enc_multi_reader #(
    .N_CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .TS_WIDTH(64)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .enc_in       (enc),
    .counter_in   (counter),
    .m_axis_tdata (tdata),
    .m_axis_tuser (tuser),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .overflow     (overflow)
`ifdef ENC_MULTI_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    counter = 64'd0;
    forever begin
      @(posedge clk);
      #1 counter = counter + 64'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Beat capture and hold-stability monitor
  logic        held = 1'b0;
  logic [63:0] h_data;
  logic [2:0]  h_user;
  logic        h_last;
  always @(negedge clk) begin
    if (held) begin
      check("hold_valid", {63'd0, tvalid}, 64'd1);
      check("hold_data", tdata, h_data);
      check("hold_user", {61'd0, tuser}, {61'd0, h_user});
      check("hold_last", {63'd0, tlast}, {63'd0, h_last});
    end
    if (tvalid && tready && !areset) q.push_back('{tdata, tuser, tlast, counter});
    held   <= tvalid && !tready && !areset;
    h_data <= tdata;
    h_user <= tuser;
    h_last <= tlast;
  end

  initial begin
    logic [63:0] c0;
    logic [2:0]  exp_user [8];
    logic [63:0] exp_data [8];
    int          hits;

    vecs[0] = '{4'b0100, 3'b101, 1'b1};
    vecs[1] = '{4'b0000, 3'b100, 1'b1};
    vecs[2] = '{4'b0010, 3'b011, 1'b1};
    vecs[3] = '{4'b0000, 3'b010, 1'b1};
    vecs[4] = '{4'b1000, 3'b111, 1'b1};
    vecs[5] = '{4'b0000, 3'b110, 1'b1};

    areset = 1'b1;
    enc    = 4'b0000;
    tready = 1'b1;
    repeat (3) step();
    check("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_tuser", {61'd0, tuser}, 64'd0);
    check("rst_tlast", {63'd0, tlast}, 64'd0);
    check("rst_overflow", {60'd0, overflow}, 64'd0);
`ifdef ENC_MULTI_DROP_CNT_EN
    check("rst_drop_cnt", {32'd0, drop_cnt}, 64'd0);
`endif
    areset = 1'b0;
    repeat (4) step();

    // Single-channel edges from the vector table
    for (int v = 0; v < 6; v++) begin
      q.delete();
      enc = vecs[v].enc;
      c0  = counter;
      repeat (14) step();
      check("vec_nbeats", q.size(), 64'd1);
      if (q.size() > 0) begin
        check("vec_tuser", {61'd0, q[0].user}, {61'd0, vecs[v].user});
        check("vec_tdata", q[0].data, c0 + 64'(LAT));
        check("vec_tlast", {63'd0, q[0].last}, {63'd0, vecs[v].last});
      end
    end

    // All channels rise together: four back-to-back beats in channel order
    q.delete();
    enc = 4'b1111;
    c0  = counter;
    repeat (14) step();
    check("all_nbeats", q.size(), 64'd4);
    if (q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("all_tuser", {61'd0, q[k].user}, {61'd0, 2'(k), 1'b1});
        check("all_tdata", q[k].data, c0 + 64'(LAT));
        check("all_tlast", {63'd0, q[k].last}, {63'd0, (k == 3)});
        check("all_consec", q[k].cyc, q[0].cyc + 64'(k));
      end
    end
    q.delete();
    enc = 4'b0000;
    repeat (14) step();
    check("all_fall_nbeats", q.size(), 64'd4);

    // Two-cycle glitch is filtered out
    q.delete();
    enc = 4'b0001;
    repeat (2) step();
    enc = 4'b0000;
    repeat (14) step();
    check("glitch2_nbeats", q.size(), 64'd0);

    // Three-cycle pulse yields a rise then a fall
    q.delete();
    enc = 4'b0001;
    c0  = counter;
    repeat (3) step();
    enc = 4'b0000;
    repeat (16) step();
    check("pulse3_nbeats", q.size(), 64'd2);
    if (q.size() == 2) begin
      check("pulse3_rise_user", {61'd0, q[0].user}, 64'd1);
      check("pulse3_rise_data", q[0].data, c0 + 64'(LAT));
      check("pulse3_fall_user", {61'd0, q[1].user}, 64'd0);
      check("pulse3_fall_data", q[1].data, c0 + 64'(LAT + 3));
      check("pulse3_fall_last", {63'd0, q[1].last}, 64'd1);
    end

    // Overflow under stalled output: third ch1 event is lost
    q.delete();
    tready = 1'b0;
    c0     = counter;
    enc[1] = 1'b1;
    repeat (6) step();
    enc[1] = 1'b0;
    repeat (6) step();
    enc[1] = 1'b1;
    repeat (10) step();
    check("ovf_flag", {60'd0, overflow}, 64'h2);
`ifdef ENC_MULTI_DROP_CNT_EN
    check("ovf_drop_cnt", {32'd0, drop_cnt}, 64'd1);
`endif
    check("ovf_stalled", q.size(), 64'd0);
    tready = 1'b1;
    repeat (6) step();
    check("ovf_nbeats", q.size(), 64'd2);
    if (q.size() == 2) begin
      check("ovf_b0_user", {61'd0, q[0].user}, 64'h3);
      check("ovf_b0_data", q[0].data, c0 + 64'(LAT));
      check("ovf_b1_user", {61'd0, q[1].user}, 64'h2);
      check("ovf_b1_data", q[1].data, c0 + 64'(LAT + 6));
    end
    check("ovf_sticky", {60'd0, overflow}, 64'h2);
    areset = 1'b1;
    enc    = 4'b0000;
    repeat (2) step();
    areset = 1'b0;
    check("ovf_clr", {60'd0, overflow}, 64'd0);
`ifdef ENC_MULTI_DROP_CNT_EN
    check("ovf_drop_clr", {32'd0, drop_cnt}, 64'd0);
`endif
    q.delete();
    repeat (4) step();

    // Random backpressure: every event delivered exactly once, stable while stalled
    for (int k = 0; k < 8; k++) begin
      enc[k % 4]  = ~enc[k % 4];
      exp_user[k] = {2'(k % 4), enc[k % 4]};
      exp_data[k] = counter + 64'(LAT);
      for (int s = 0; s < 7; s++) begin
        tready = 1'($urandom_range(0, 1));
        step();
      end
    end
    for (int s = 0; s < 40; s++) begin
      tready = 1'($urandom_range(0, 1));
      step();
    end
    tready = 1'b1;
    repeat (20) step();
    check("bp_nbeats", q.size(), 64'd8);
    for (int k = 0; k < 8; k++) begin
      hits = 0;
      foreach (q[j]) begin
        if (q[j].user == exp_user[k] && q[j].data == exp_data[k]) hits++;
      end
      check("bp_unique", 64'(hits), 64'd1);
    end
    check("bp_no_ovf", {60'd0, overflow}, 64'd0);

    // Reset while a beat is stalled and two slots are pending
    q.delete();
    tready = 1'b0;
    enc    = 4'b0111;
    repeat (12) step();
    check("rstx_pre_valid", {63'd0, tvalid}, 64'd1);
    areset = 1'b1;
    enc    = 4'b0000;
    step();
    areset = 1'b0;
    check("rstx_valid", {63'd0, tvalid}, 64'd0);
    check("rstx_overflow", {60'd0, overflow}, 64'd0);
    q.delete();
    tready = 1'b1;
    repeat (20) step();
    check("rstx_no_stale", q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
